// File: rtl/sphere_closest_hit_resolver_pkg.sv
// sphere_closest_hit_resolver_pkg: shared hit record types, hit epsilon and resolver states
package sphere_closest_hit_resolver_pkg;
  typedef logic signed [31:0] Fixed;
  typedef struct packed {
    logic        bHit;
    Fixed        T;
    Fixed        nx;
    Fixed        ny;
    Fixed        nz;
    logic [23:0] color;
    logic [15:0] vi;
    logic [31:0] st;
  } HitData;
  localparam Fixed FIXED_HIT_EPSILON = 32'sh0000_0040;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} ResolverState;
endpackage

// File: rtl/hit_nearer_cmp.sv
// hit_nearer_cmp: decides whether a candidate hit is acceptable and nearer than the current best
module hit_nearer_cmp
  import sphere_closest_hit_resolver_pkg::*;
(
  input  HitData i_cand,
  input  HitData i_best,
  input  logic   i_best_valid,
  input  Fixed   i_eps,
  output logic   o_qualify,
  output logic   o_replace
);
  assign o_qualify = i_cand.bHit && ($signed(i_cand.T) > $signed(i_eps));
  // strict less-than keeps the earlier candidate on equal distance
  assign o_replace = o_qualify && (!i_best_valid || $signed(i_cand.T) < $signed(i_best.T));
endmodule

// File: rtl/sphere_closest_hit_resolver.sv
// sphere_closest_hit_resolver: reduces a per-ray stream of sphere hit candidates to the nearest valid hit
module sphere_closest_hit_resolver
  import sphere_closest_hit_resolver_pkg::*;
#(
  parameter int   RAY_ID_W  = 8,
  parameter int   CNT_W     = 8,
  parameter Fixed T_EPSILON = FIXED_HIT_EPSILON
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  HitData              in_hit,
  input  logic [RAY_ID_W-1:0] in_ray_id,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output HitData              out_hit,
  output logic [RAY_ID_W-1:0] out_ray_id,
  output logic [CNT_W-1:0]    out_cand_cnt,
  output logic                err_id_mismatch
);
  ResolverState        r_state, w_next;
  HitData              r_best;
  logic                r_best_vld;
  logic [RAY_ID_W-1:0] r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic                w_acc, w_open, w_qualify, w_replace;
  assign out_valid       = r_state == EMIT;
  assign out_hit         = r_best;
  assign out_ray_id      = r_id;
  assign out_cand_cnt    = r_cnt;
  assign err_id_mismatch = r_err;
  // a result draining this cycle frees the slot for the next ray's first candidate
  assign in_ready = resetn && (r_state != EMIT || out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_open   = w_acc && r_state != ACCUM;
  hit_nearer_cmp u_cmp (
    .i_cand      (in_hit),
    .i_best      (r_best),
    .i_best_valid(r_best_vld && !w_open),
    .i_eps       (T_EPSILON),
    .o_qualify   (w_qualify),
    .o_replace   (w_replace)
  );
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = in_last ? EMIT : ACCUM;
    else if (out_valid && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_best     <= '0;
      r_best_vld <= 1'b0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        if (w_replace) r_best <= in_hit;
        else if (w_open) r_best <= '0;
        r_best_vld <= w_open ? w_qualify : (r_best_vld || w_qualify);
        r_id       <= w_open ? in_ray_id : r_id;
        r_cnt      <= w_open ? CNT_W'(1) : r_cnt + CNT_W'(r_cnt != '1);
        r_err      <= r_err || (!w_open && in_ray_id != r_id);
      end
    end
  end
endmodule

// File: tb/tb_sphere_closest_hit_resolver.sv
// tb_sphere_closest_hit_resolver: scoreboard bench comparing resolved hits with a nearest-hit reference model
module tb_sphere_closest_hit_resolver;
  import sphere_closest_hit_resolver_pkg::*;
  localparam Fixed EPS = 32'sh0000_0040;
  typedef struct {
    HitData     h;
    logic [7:0] id;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, err_id_mismatch;
  HitData in_hit = '0, out_hit;
  logic [7:0] in_ray_id = '0, out_ray_id, out_cand_cnt;

  sphere_closest_hit_resolver dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_hit(in_hit), .in_ray_id(in_ray_id), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_ray_id(out_ray_id), .out_cand_cnt(out_cand_cnt),
    .err_id_mismatch(err_id_mismatch)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  exp_t q[$];
  int out_cycs[$];
  HitData cur[$];
  logic [7:0] cur_id;
  bit rnd_bp = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit qual(input HitData h);
    return h.bHit && $signed(h.T) > $signed(EPS);
  endfunction

  // nearest qualifying distance first, then the earliest candidate at that distance
  function automatic HitData ref_best(input HitData c[$]);
    Fixed m = '0;
    bit f = 0;
    for (int i = 0; i < c.size(); i++)
      if (qual(c[i]) && (!f || $signed(c[i].T) < $signed(m))) begin
        m = c[i].T;
        f = 1;
      end
    for (int i = 0; i < c.size(); i++)
      if (f && qual(c[i]) && c[i].T == m) return c[i];
    return '0;
  endfunction

  function automatic HitData mk(input logic b, input Fixed t);
    HitData h;
    h.bHit = b; h.T = t;
    h.nx = $urandom; h.ny = $urandom; h.nz = $urandom;
    h.color = 24'($urandom); h.vi = 16'($urandom); h.st = $urandom;
    return h;
  endfunction

  function automatic Fixed rnd_t();
    case ($urandom_range(0, 5))
      0: return EPS;
      1: return EPS + 1;
      2: return 32'sh0002_0000;
      3: return -Fixed'($urandom_range(0, 65536));
      default: return Fixed'($urandom_range(0, 32'h000F_FFFF));
    endcase
  endfunction

  task automatic send(input HitData h, input logic [7:0] id, input bit last, output int waits);
    in_valid = 1; in_hit = h; in_ray_id = id; in_last = last; waits = 0;
    if (rnd_bp) out_ready = $urandom_range(0, 3) != 0;
    @(negedge clk);
    while (!in_ready) begin
      waits++;
      if (waits > 50) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1, "handshake stalled");
      end
      @(posedge clk); #1;
      if (rnd_bp) out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (cur.size() == 0) cur_id = id;
    cur.push_back(h);
    if (last) begin
      q.push_back('{ref_best(cur), cur_id, (cur.size() > 255) ? 8'd255 : 8'(cur.size())});
      cur.delete();
      check("latency_out_valid", out_valid, 1'b1);
    end
  endtask

  task automatic chk_reset();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_hit", out_hit, '0);
    check("rst_out_ray_id", out_ray_id, '0);
    check("rst_out_cand_cnt", out_cand_cnt, '0);
    check("rst_err", err_id_mismatch, 1'b0);
  endtask

  HitData hold_hit;
  logic [7:0] hold_id;
  bit hold_v = 0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !out_ready) begin
      if (hold_v) begin
        check("hold_out_hit", out_hit, hold_hit);
        check("hold_out_ray_id", out_ray_id, hold_id);
      end
      hold_v = 1; hold_hit = out_hit; hold_id = out_ray_id;
    end else hold_v = 0;
    if (out_valid && out_ready) begin
      out_cycs.push_back(cyc);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got id %0d expected no output", out_ray_id);
      end else begin
        e = q.pop_front();
        check("out_hit", out_hit, e.h);
        check("out_ray_id", out_ray_id, e.id);
        check("out_cand_cnt", out_cand_cnt, e.cnt);
      end
    end
  end

  initial begin
    int w, wsum, n0, len;
    HitData a, b;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1 resetn = 1;
    // nearest of three
    send(mk(1, 32'sh0005_0000), 8'd1, 0, w);
    send(mk(1, 32'sh0002_0000), 8'd1, 0, w);
    send(mk(1, 32'sh0003_8000), 8'd1, 1, w);
    check("t1_T", out_hit.T, 32'h0002_0000);
    check("t1_cnt", out_cand_cnt, 8'd3);
    // nothing qualifies
    send(mk(0, 32'sh0001_0000), 8'd2, 0, w);
    send(mk(1, 32'sh0000_0000), 8'd2, 0, w);
    send(mk(1, 32'shFFFF_0000), 8'd2, 1, w);
    check("t2_empty_hit", out_hit, '0);
    check("t2_cnt", out_cand_cnt, 8'd3);
    // tie keeps the first
    a = mk(1, 32'sh0004_0000);
    b = mk(1, 32'sh0004_0000);
    b.color = ~a.color;
    send(a, 8'd4, 0, w);
    send(b, 8'd4, 1, w);
    check("t3_tie", out_hit, a);
    // back-to-back rays with no bubble
    repeat (2) @(posedge clk); #1;
    n0 = out_cycs.size(); wsum = 0;
    send(mk(1, rnd_t()), 8'd7, 0, w); wsum += w;
    send(mk(1, rnd_t()), 8'd7, 1, w); wsum += w;
    send(mk(1, rnd_t()), 8'd8, 1, w); wsum += w;
    check("t4_no_stall", wsum, 0);
    repeat (3) @(posedge clk); #1;
    if (out_cycs.size() >= n0 + 2) check("t4_consecutive", out_cycs[n0+1] - out_cycs[n0], 1);
    else check("t4_out_count", out_cycs.size() - n0, 2);
    // backpressure, then drain and accept in the same cycle
    out_ready = 0;
    send(mk(1, rnd_t()), 8'd20, 1, w);
    fork begin repeat (5) @(posedge clk); #1 out_ready = 1; end join_none
    send(mk(1, rnd_t()), 8'd21, 1, w);
    check("t5_in_ready_low_cycles", w, 5);
    check("t5_next_id", out_ray_id, 8'd21);
    // id mismatch inside a ray
    send(mk(1, rnd_t()), 8'd9, 0, w);
    check("t6_err_before", err_id_mismatch, 1'b0);
    send(mk(1, rnd_t()), 8'd10, 1, w);
    check("t6_err_set", err_id_mismatch, 1'b1);
    // counter saturation
    for (int i = 0; i < 260; i++) send(mk($urandom_range(0, 1), rnd_t()), 8'd30, i == 259, w);
    check("t7_cnt_sat", out_cand_cnt, 8'd255);
    // randomized rays under random backpressure
    rnd_bp = 1;
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 6);
      n0 = $urandom_range(0, 255);
      for (int i = 0; i < len; i++) send(mk($urandom_range(0, 3) != 0, rnd_t()), 8'(n0), i == len - 1, w);
      if ($urandom_range(0, 3) == 0) begin repeat ($urandom_range(1, 3)) @(posedge clk); #1; end
    end
    rnd_bp = 0;
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    check("t8_err_sticky", err_id_mismatch, 1'b1);
    check("t8_drained", q.size(), 0);
    // reset in the middle of a ray
    send(mk(1, rnd_t()), 8'd5, 0, w);
    send(mk(1, rnd_t()), 8'd5, 0, w);
    resetn = 0;
    cur.delete();
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1 resetn = 1;
    send(mk(1, 32'sh0001_0000), 8'd3, 1, w);
    check("t9_T", out_hit.T, 32'h0001_0000);
    check("t9_cnt", out_cand_cnt, 8'd1);
    check("t9_id", out_ray_id, 8'd3);
    repeat (5) @(posedge clk); #1;
    check("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sphere_closest_hit_resolver.md
Name: sphere_closest_hit_resolver

Overview:
- Sits directly downstream of the per-primitive sphere hit stage in the BVH leaf path.
- Consumes a stream of candidate HitData records for one ray at a time, one candidate per primitive tested.
- Keeps the nearest valid hit and emits one resolved HitData per ray to the shading/trace-result stage.
- Uses valid/ready handshakes on both sides, with a registered output slot.

Parameters:
- RAY_ID_W, 8, width of the ray tag carried alongside each candidate.
- CNT_W, 8, width of the per-ray candidate counter (saturating).
- T_EPSILON, 32'h0000_0040, minimum accepted hit distance (Fixed raw); candidates with T <= T_EPSILON are rejected as self-intersections.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  candidate present.
- in_ready  out  1  resolver accepts a candidate this cycle.
- in_hit  in  $bits(HitData)  candidate hit record from the sphere hit stage (bHit, T, normal, color, vi, st).
- in_ray_id  in  RAY_ID_W  tag of the ray the candidate belongs to.
- in_last  in  1  final candidate for this ray.
- out_valid  out  1  resolved hit available.
- out_ready  in  1  downstream accepts the result.
- out_hit  out  $bits(HitData)  nearest accepted hit; bHit=0 if none.
- out_ray_id  out  RAY_ID_W  tag of the resolved ray.
- out_cand_cnt  out  CNT_W  number of candidates consumed for this ray (saturates at all-ones).
- err_id_mismatch  out  1  sticky; set when a non-first candidate carries a different ray_id than the open ray.

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out_hit=0 (bHit=0, T=0), out_ray_id=0, out_cand_cnt=0, err_id_mismatch=0.
  - Best register cleared; in_ready reads 0 while resetn is low.
  - A reset mid-ray discards the partial result; nothing is emitted.
- Handshake:
  - A transfer occurs on a rising edge with valid&&ready.
  - in_ready = (state != EMIT) || (out_ready && out_valid), so a pending result draining in the same cycle frees the slot.
  - in_ready has no combinational dependence on in_valid.
- States:
  - IDLE: no open ray. An accepted candidate opens a ray: best <= candidate if it qualifies, else empty; ray_id latched; cnt=1. If in_last is also set, go to EMIT, else to ACCUM.
  - ACCUM: each accepted candidate is compared against best; cnt increments and saturates at 2^CNT_W-1. in_last moves to EMIT.
  - EMIT: out_valid=1 with out_hit=best, out_ray_id, out_cand_cnt. On out_ready, go to IDLE, or directly open the next ray if a candidate is accepted in that same cycle.
- Qualification rule: a candidate qualifies iff bHit=1 and signed T > T_EPSILON.
- Replace rule:
  - A qualifying candidate replaces best iff best is empty or cand.T < best.T (signed compare, full Fixed width).
  - On equal T the earlier candidate is kept.
  - The whole HitData record is replaced atomically; no field mixing.
- Latency: the result is registered. out_valid rises on the cycle after in_last is accepted, giving 1-cycle latency from the last candidate.
- Throughput: one candidate per cycle, including back-to-back rays with no bubble as long as out_ready=1.
- Empty ray: if no candidate qualifies, out_hit has bHit=0 and the other fields are zero.
- ID check: in ACCUM, an in_ray_id differing from the latched id sets err_id_mismatch, which is cleared only by reset. The candidate is still processed.
- Outputs in EMIT are held stable while out_ready=0.

Decomposition:
- Shared types package (the existing Types definitions):
  - HitData and Fixed types, already shared.
  - Add the T_EPSILON default constant as `FIXED_HIT_EPSILON.
  - Add a ResolverState enum {IDLE, ACCUM, EMIT}.
- One sub-module, hit_nearer_cmp: combinational; takes candidate HitData, best HitData, best_valid and epsilon; outputs qualify and replace. This lets it be reused by the AABB/triangle resolvers.

Test Plan:
- Single ray, 3 candidates T={5.0, 2.0, 3.5}, all bHit=1, last on the third → one output with T=2.0, out_cand_cnt=3, out_valid one cycle after the last transfer.
- Ray with candidates {bHit=0; bHit=1 T=0.0; bHit=1 T=-1.0} → out_hit.bHit=0, T=0, cnt=3.
- Tie: T=4.0 with color A, then T=4.0 with color B → output color A.
- Back-to-back: ray 7 (2 candidates) then ray 8 (1 candidate), out_ready=1 constantly → in_ready stays 1, two results in consecutive order with ids 7 and 8, no bubble.
- Backpressure: hold out_ready=0 for 5 cycles during EMIT → in_ready=0, out_hit stable. Raising out_ready with in_valid high must drain and accept in the same cycle.
- Reset mid-ACCUM after 2 candidates, then a fresh ray (id 3, single candidate T=1.0) → no stale output; result T=1.0 cnt=1. Additionally, a mismatched id within a ray sets err_id_mismatch and it stays set.
